// File: rtl/stop_it_gen_pkg.sv
// stop_it_gen_pkg: shared state encoding, LFSR tap masks and level-to-period mapping.
package stop_it_gen_pkg;

    typedef enum logic [2:0] {
        IDLE, STARTING, DECREMENTING, CORRECT, WRONG, WON, LOST
    } state_t;

    // Galois right-shift masks for maximal-length sequences, widths 3..16
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            default: return 16'hD008;
        endcase
    endfunction

    function automatic int period_for(input int period0, input int level);
        int p;
        p = period0 >> level;
        return (p < 1) ? 1 : p;
    endfunction

endpackage

// File: rtl/stop_it_gen_lfsr_n.sv
// lfsr_n: Galois LFSR seeded with 1, advancing only when next_i is high.
module lfsr_n
    import stop_it_gen_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk_4_i,
    input  logic             rst_ni,
    input  logic             next_i,
    output logic [WIDTH-1:0] rand_o
);

    localparam logic [WIDTH-1:0] MASK = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] rand_q, rand_d;

    always_comb begin
        rand_d = next_i ? ((rand_q >> 1) ^ (rand_q[0] ? MASK : '0)) : rand_q;
    end

    always_ff @(posedge clk_4_i or negedge rst_ni) begin
        if (!rst_ni) rand_q <= WIDTH'(1);
        else         rand_q <= rand_d;
    end

    assign rand_o = rand_q;

endmodule

// File: rtl/stop_it_gen.sv
// stop_it_gen: Stop-It reaction game with lives, speed-up levels and restart from WON/LOST.
// Define STOP_IT_GEN_PENALTY_EN to make each miss also shift one LED off the score bar.
module stop_it_gen
    import stop_it_gen_pkg::*;
#(
    parameter int CNT_W         = 5,
    parameter int N_LEDS        = 16,
    parameter int START_TICKS   = 8,
    parameter int RESULT_TICKS  = 16,
    parameter int MAX_LIVES     = 3,
    parameter int PERIOD0       = 4,
    parameter int SPEEDUP_EVERY = 4
) (
    input  logic                           clk_4_i,
    input  logic                           rst_ni,
    input  logic                           go_i,
    input  logic                           stop_i,
    input  logic                           load_i,
    input  logic [N_LEDS-1:0]              switches_i,
    output logic [N_LEDS-1:0]              leds_o,
    output logic [CNT_W-1:0]               count_o,
    output logic [CNT_W-1:0]               target_o,
    output logic                           count_en_o,
    output logic                           target_en_o,
    output logic [$clog2(MAX_LIVES+1)-1:0] lives_o,
    output state_t                         state_o
);

    localparam int TMAX    = (START_TICKS > RESULT_TICKS) ? START_TICKS : RESULT_TICKS;
    localparam int TW      = $clog2(TMAX + 1);
    localparam int LW      = $clog2(MAX_LIVES + 1);
    localparam int LVL_MAX = $clog2(PERIOD0);
    localparam int LVW     = $clog2(LVL_MAX + 2);
    localparam int PW      = $clog2(PERIOD0 + 1);
    localparam int HW      = $clog2(SPEEDUP_EVERY + 1);

    state_t            state_q, state_d;
    logic [N_LEDS-1:0] leds_q, leds_d, leds_shift;
    logic [CNT_W-1:0]  count_q, count_d, target_q, target_d, rand_val;
    logic [LW-1:0]     lives_q, lives_d;
    logic [LVW-1:0]    level_q, level_d;
    logic [HW-1:0]     hits_q, hits_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [PW-1:0]     pcnt_q, pcnt_d, period;

    lfsr_n #(.WIDTH(CNT_W)) u_lfsr (
        .clk_4_i (clk_4_i),
        .rst_ni  (rst_ni),
        .next_i  (state_q == IDLE),
        .rand_o  (rand_val)
    );

    assign period     = PW'(period_for(PERIOD0, int'(level_q)));
    assign leds_shift = {leds_q[N_LEDS-2:0], 1'b1};

    always_comb begin
        state_d  = state_q;
        leds_d   = leds_q;
        count_d  = count_q;
        target_d = target_q;
        lives_d  = lives_q;
        level_d  = level_q;
        hits_d   = hits_q;
        timer_d  = timer_q;
        pcnt_d   = pcnt_q;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (load_i) leds_d = switches_i;
                if (go_i) begin
                    target_d = rand_val;
                    state_d  = STARTING;
                end
            end
            STARTING: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == TW'(START_TICKS - 1)) begin
                    count_d = '1;
                    pcnt_d  = '0;
                    timer_d = '0;
                    state_d = DECREMENTING;
                end
            end
            DECREMENTING: begin
                // stop wins over a same-cycle decrement so the compared value is what the player saw
                if (stop_i) begin
                    pcnt_d  = '0;
                    state_d = (count_q == target_q) ? CORRECT : WRONG;
                end else if (pcnt_q == period - PW'(1)) begin
                    count_d = count_q - CNT_W'(1);
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            CORRECT: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == TW'(RESULT_TICKS - 1)) begin
                    timer_d = '0;
                    leds_d  = leds_shift;
                    hits_d  = (hits_q == HW'(SPEEDUP_EVERY - 1)) ? '0 : hits_q + HW'(1);
                    if (hits_q == HW'(SPEEDUP_EVERY - 1) && level_q != LVW'(LVL_MAX))
                        level_d = level_q + LVW'(1);
                    state_d = (&leds_shift) ? WON : IDLE;
                end
            end
            WRONG: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == TW'(RESULT_TICKS - 1)) begin
                    timer_d = '0;
                    lives_d = lives_q - LW'(1);
`ifdef STOP_IT_GEN_PENALTY_EN
                    leds_d  = {1'b0, leds_q[N_LEDS-1:1]};
`endif
                    state_d = (lives_q == LW'(1)) ? LOST : IDLE;
                end
            end
            WON, LOST: begin
                timer_d = timer_q + TW'(1);
                if (go_i) begin
                    leds_d  = '0;
                    lives_d = LW'(MAX_LIVES);
                    level_d = '0;
                    hits_d  = '0;
                    timer_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            leds_q   <= '0;
            count_q  <= '1;
            target_q <= '0;
            lives_q  <= LW'(MAX_LIVES);
            level_q  <= '0;
            hits_q   <= '0;
            timer_q  <= '0;
            pcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            leds_q   <= leds_d;
            count_q  <= count_d;
            target_q <= target_d;
            lives_q  <= lives_d;
            level_q  <= level_d;
            hits_q   <= hits_d;
            timer_q  <= timer_d;
            pcnt_q   <= pcnt_d;
        end
    end

    assign leds_o      = (state_q == WON && timer_q[0]) ? '0 : leds_q;
    assign count_en_o  = (state_q inside {DECREMENTING, WRONG, LOST}) || (state_q == CORRECT && !timer_q[0]);
    assign target_en_o = (state_q == LOST) || ((state_q inside {CORRECT, WRONG}) && !timer_q[0]);
    assign count_o     = count_q;
    assign target_o    = target_q;
    assign lives_o     = lives_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_stop_it_gen.sv
// tb_stop_it_gen: scoreboard bench for stop_it_gen at default parameters.
module tb_stop_it_gen;
    import stop_it_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0, stop = 1'b0, load = 1'b0;
    logic [15:0] switches = '0;
    logic [15:0] leds_o;
    logic [4:0]  count_o, target_o;
    logic        count_en_o, target_en_o;
    logic [1:0]  lives_o;
    state_t      state_o;

    int          checks = 0, errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    logic [4:0]  m_lfsr, tgt;
    bit          m_idle = 1'b0;
    logic [15:0] m_leds = '0;
    int          m_lives = 3, m_hits = 0, m_level = 0;

    stop_it_gen dut (
        .clk_4_i     (clk),
        .rst_ni      (rst_n),
        .go_i        (go),
        .stop_i      (stop),
        .load_i      (load),
        .switches_i  (switches),
        .leds_o      (leds_o),
        .count_o     (count_o),
        .target_o    (target_o),
        .count_en_o  (count_en_o),
        .target_en_o (target_en_o),
        .lives_o     (lives_o),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    // x^5 + x^3 + 1 in right-shift Galois form
    function automatic logic [4:0] gal(input logic [4:0] s);
        return s[0] ? ((s >> 1) ^ 5'h14) : (s >> 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      m_lfsr <= 5'd1;
        else if (m_idle) m_lfsr <= gal(m_lfsr);
    end

    task automatic start_round(input logic [15:0] sw, input bit ld);
        switches = sw; load = ld; go = 1'b1;
        tgt = m_lfsr;
        exp_q.push_back({27'd0, m_lfsr});
        if (ld) m_leds = sw;
        @(negedge clk); go = 1'b0; load = 1'b0; m_idle = 1'b0;
        e = exp_q.pop_front();
        checks++; if (target_o !== e[4:0]) begin errors++; $display("FAIL target: got %0d exp %0d", target_o, e[4:0]); end
        checks++; if (state_o !== STARTING) begin errors++; $display("FAIL enter_starting: got %0d exp %0d", state_o, STARTING); end
        repeat (7) @(negedge clk);
        checks++; if (state_o !== STARTING) begin errors++; $display("FAIL starting_len: got %0d exp %0d", state_o, STARTING); end
        @(negedge clk);
        checks++; if (state_o !== DECREMENTING || count_o !== 5'd31) begin errors++; $display("FAIL enter_dec: state %0d count %0d exp %0d 31", state_o, count_o, DECREMENTING); end
        checks++; if ({count_en_o, target_en_o} !== 2'b10) begin errors++; $display("FAIL dec_en: got %b exp 10", {count_en_o, target_en_o}); end
    endtask

    task automatic finish_round(input bit hit);
        int p, idx;
        state_t nxt;
        p = 4 >> m_level; if (p < 1) p = 1;
        idx = hit ? ((31 - int'(tgt)) & 31) : ((30 - int'(tgt)) & 31);
        if (idx == 0) idx = 32;
        repeat (p - 1) @(negedge clk);
        checks++; if (count_o !== 5'd31) begin errors++; $display("FAIL period_hold: got %0d exp 31 (p=%0d)", count_o, p); end
        @(negedge clk);
        checks++; if (count_o !== 5'd30) begin errors++; $display("FAIL period_dec: got %0d exp 30 (p=%0d)", count_o, p); end
        repeat (p * idx - p) @(negedge clk);
        checks++; if (count_o !== 5'((31 - idx) & 31)) begin errors++; $display("FAIL count_at_stop: got %0d exp %0d", count_o, (31 - idx) & 31); end
        stop = 1'b1;
        exp_q.push_back(hit ? 32'(CORRECT) : 32'(WRONG));
        @(negedge clk); stop = 1'b0;
        e = exp_q.pop_front();
        checks++; if (state_o !== state_t'(e[2:0])) begin errors++; $display("FAIL result_state: got %0d exp %0d", state_o, e[2:0]); end
        checks++; if ({count_en_o, target_en_o} !== 2'b11) begin errors++; $display("FAIL result_en0: got %b exp 11", {count_en_o, target_en_o}); end
        @(negedge clk);
        checks++; if ({count_en_o, target_en_o} !== (hit ? 2'b00 : 2'b10)) begin errors++; $display("FAIL result_en1: got %b exp %b", {count_en_o, target_en_o}, hit ? 2'b00 : 2'b10); end
        repeat (14) @(negedge clk);
        checks++; if (state_o !== (hit ? CORRECT : WRONG)) begin errors++; $display("FAIL result_len: got %0d", state_o); end
        if (hit) begin
            m_leds = {m_leds[14:0], 1'b1};
            m_hits++;
            if (m_hits == 4) begin m_hits = 0; if (m_level < 2) m_level++; end
            nxt = (m_leds == 16'hFFFF) ? WON : IDLE;
        end else begin
            m_lives--;
`ifdef STOP_IT_GEN_PENALTY_EN
            m_leds = m_leds >> 1;
`endif
            nxt = (m_lives == 0) ? LOST : IDLE;
        end
        exp_q.push_back(32'(nxt)); exp_q.push_back({16'd0, m_leds}); exp_q.push_back(32'(m_lives));
        @(negedge clk);
        m_idle = (nxt == IDLE);
        e = exp_q.pop_front();
        checks++; if (state_o !== state_t'(e[2:0])) begin errors++; $display("FAIL exit_state: got %0d exp %0d", state_o, e[2:0]); end
        e = exp_q.pop_front();
        checks++; if (leds_o !== e[15:0]) begin errors++; $display("FAIL exit_leds: got %h exp %h", leds_o, e[15:0]); end
        e = exp_q.pop_front();
        checks++; if (lives_o !== e[1:0]) begin errors++; $display("FAIL exit_lives: got %0d exp %0d", lives_o, e[1:0]); end
    endtask

    task automatic restart();
        go = 1'b1;
        @(negedge clk); go = 1'b0; m_idle = 1'b1;
        m_leds = '0; m_lives = 3; m_hits = 0; m_level = 0;
        checks++; if (state_o !== IDLE || leds_o !== 16'h0 || lives_o !== 2'd3) begin errors++; $display("FAIL restart: state %0d leds %h lives %0d exp 0 0000 3", state_o, leds_o, lives_o); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (state_o !== IDLE || leds_o !== 16'h0 || count_o !== 5'd31 || target_o !== 5'd0 || lives_o !== 2'd3) begin
            errors++; $display("FAIL reset_vals: state %0d leds %h count %0d target %0d lives %0d", state_o, leds_o, count_o, target_o, lives_o); end
        checks++; if ({count_en_o, target_en_o} !== 2'b00) begin errors++; $display("FAIL reset_en: got %b exp 00", {count_en_o, target_en_o}); end
        rst_n = 1'b1; m_idle = 1'b1;
        repeat (3) @(negedge clk);
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        checks++; if (state_o !== IDLE) begin errors++; $display("FAIL stop_in_idle: got %0d exp %0d", state_o, IDLE); end
    endtask

    task automatic test_countdown();
        start_round(16'h0, 1'b0);
        repeat (3) @(negedge clk);
        checks++; if (count_o !== 5'd31) begin errors++; $display("FAIL cd_hold: got %0d exp 31", count_o); end
        load = 1'b1; switches = 16'hFFFF; go = 1'b1;
        @(negedge clk); load = 1'b0; go = 1'b0; switches = '0;
        checks++; if (count_o !== 5'd30 || state_o !== DECREMENTING) begin errors++; $display("FAIL cd_first: count %0d state %0d exp 30 %0d", count_o, state_o, DECREMENTING); end
        repeat (120) @(negedge clk);
        checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL cd_zero: got %0d exp 0", count_o); end
        repeat (4) @(negedge clk);
        checks++; if (count_o !== 5'd31) begin errors++; $display("FAIL cd_wrap: got %0d exp 31", count_o); end
        finish_round(1'b1);
    endtask

    task automatic test_speedup();
        for (int i = 0; i < 4; i++) begin
            start_round(16'h0, 1'b0);
            finish_round(1'b1);
        end
        checks++; if (m_level != 1 || leds_o !== 16'h001F) begin errors++; $display("FAIL speedup_prep: leds %h exp 001f", leds_o); end
    endtask

    task automatic test_won();
        start_round(16'h7FFF, 1'b1);
        finish_round(1'b1);
        @(negedge clk);
        checks++; if (leds_o !== 16'h0000) begin errors++; $display("FAIL won_flash_off: got %h exp 0000", leds_o); end
        @(negedge clk);
        checks++; if (leds_o !== 16'hFFFF || {count_en_o, target_en_o} !== 2'b00) begin errors++; $display("FAIL won_flash_on: leds %h en %b exp ffff 00", leds_o, {count_en_o, target_en_o}); end
        restart();
    endtask

    task automatic test_lives();
        start_round(16'h000F, 1'b1);
        finish_round(1'b0);
        for (int i = 0; i < 2; i++) begin
            start_round(16'h0, 1'b0);
            finish_round(1'b0);
        end
        repeat (3) @(negedge clk);
        checks++; if (state_o !== LOST || {count_en_o, target_en_o} !== 2'b11) begin errors++; $display("FAIL lost_hold: state %0d en %b exp %0d 11", state_o, {count_en_o, target_en_o}, LOST); end
        restart();
    endtask

    task automatic test_async_reset();
        start_round(16'h0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (state_o !== IDLE || count_o !== 5'd31 || target_o !== 5'd0 || leds_o !== 16'h0 || lives_o !== 2'd3) begin
            errors++; $display("FAIL async_reset: state %0d count %0d target %0d leds %h lives %0d", state_o, count_o, target_o, leds_o, lives_o); end
        @(negedge clk); rst_n = 1'b1; m_idle = 1'b1;
        m_leds = '0; m_lives = 3; m_hits = 0; m_level = 0;
        repeat (2) @(negedge clk);
        start_round(16'h0, 1'b0);
        finish_round(1'b1);
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_speedup();
        test_won();
        test_lives();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
